ipf_seq: RTL and testbench

Sequencer that drives one IPF convolution engine from two streaming sources: a weight stream and an input-row stream. It accepts one layer configuration and then generates the whole IPF control sequence with no further software involvement. The sequence covers weight load, per-round preload under hold, start beats with wround/wgroup stepping, drain, end, and waiting for IPF `finish`. It sits between the layer DMA/buffer logic and the IPF instance and owns every IPF control input.

---
 rtl/ipf_seq.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ipf_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipf_seq.sv
// ipf_seq: drives one IPF engine through weight load, preload, start and drain.
// Stride-2 mode is present only when IPF_SEQ_STRIDE2_EN is defined.
module ipf_seq #(
  parameter int DATA_W    = 64,
  parameter int DRAIN_CYC = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_wsize,
  input  logic              cfg_stride,
  input  logic [7:0]        cfg_tiles,
  input  logic [3:0]        cfg_group,
  input  logic [1:0]        cfg_pad,
  input  logic              w_in_valid,
  output logic              w_in_ready,
  input  logic [DATA_W-1:0] w_in_data,
  input  logic              i_in_valid,
  output logic              i_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic [1:0]        ctrl,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  output logic [1:0]        Wsize,
  output logic              stride,
  output logic [1:0]        RLPadding,
  output logic [3:0]        wgroup,
  output logic [2:0]        wround,
  input  logic              finish,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_PRE, S_RUN, S_DRAIN, S_END
  } state_t;

  localparam logic [1:0] C_END   = 2'd0;
  localparam logic [1:0] C_START = 2'd1;
  localparam logic [1:0] C_HOLD  = 2'd2;
  localparam logic [3:0] DRN_LAST = 4'(DRAIN_CYC - 1);

  state_t state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [1:0]  round_q, round_d;
  logic [3:0]  drn_q, drn_d;
  logic [7:0]  tiles_q, tiles_d;
  logic [3:0]  group_q, group_d;
  logic [1:0]  wsize_q, wsize_d;
  logic        stride_q, stride_d;
  logic [1:0]  pad_q, pad_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        w_valid_q, w_valid_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic        i_valid_q, i_valid_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic [3:0]  wgroup_q, wgroup_d;
  logic [2:0]  wround_q, wround_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [4:0]  wbeats;
  logic [2:0]  pbeats;
  logic [1:0]  rlast;
  logic [10:0] sbeats;
  logic        s2;
  logic [3:0]  grp_beat;

`ifdef IPF_SEQ_STRIDE2_EN
  logic ph_q, ph_d;
  assign s2       = stride_q;
  assign grp_beat = s2 ? {3'b000, ph_q} : group_q;
`else
  logic unused_stride;
  assign unused_stride = cfg_stride;
  assign s2            = 1'b0;
  assign grp_beat      = group_q;
`endif

  always_comb begin
    wbeats = 5'd18;
    pbeats = 3'd2;
    rlast  = 2'd0;
    unique case (1'b1)
      (wsize_q == 2'd1): begin
        wbeats = 5'd25;
        pbeats = 3'd4;
        rlast  = 2'd1;
      end
      (wsize_q == 2'd2): begin
        wbeats = 5'd25;
        pbeats = 3'd6;
        rlast  = s2 ? 2'd1 : 2'd3;
      end
      default: ;
    endcase
    sbeats = 11'(4'd8 - {1'b0, pbeats}) + {tiles_q, 3'b000};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    round_d    = round_q;
    drn_d      = drn_q;
    tiles_d    = tiles_q;
    group_d    = group_q;
    wsize_d    = wsize_q;
    stride_d   = stride_q;
    pad_d      = pad_q;
    ctrl_d     = C_HOLD;
    w_valid_d  = 1'b0;
    w_data_d   = '0;
    i_valid_d  = 1'b0;
    i_data_d   = '0;
    wgroup_d   = wgroup_q;
    wround_d   = {1'b0, round_q};
    done_d     = 1'b0;
    err_d      = 1'b0;
    cfg_ready  = 1'b0;
    w_in_ready = 1'b0;
    i_in_ready = 1'b0;
`ifdef IPF_SEQ_STRIDE2_EN
    ph_d       = ph_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        wround_d  = 3'd0;
        if (cfg_valid) begin
          if (cfg_wsize == 2'd3) begin
            err_d = 1'b1;
          end else begin
            wsize_d = cfg_wsize;
`ifdef IPF_SEQ_STRIDE2_EN
            stride_d = cfg_stride;
`endif
            pad_d   = cfg_pad;
            tiles_d = cfg_tiles;
            group_d = cfg_group;
            cnt_d   = '0;
            round_d = '0;
            state_d = S_WLOAD;
          end
        end
      end
      S_WLOAD: begin
        w_in_ready = 1'b1;
        wround_d   = 3'd0;
        if (w_in_valid) begin
          w_valid_d = 1'b1;
          w_data_d  = w_in_data;
          if (cnt_q == {6'd0, wbeats - 5'd1}) begin
            cnt_d   = '0;
            state_d = S_PRE;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end
      S_PRE: begin
        i_in_ready = 1'b1;
        if (i_in_valid) begin
          i_valid_d = 1'b1;
          i_data_d  = i_in_data;
          if (cnt_q == {8'd0, pbeats - 3'd1}) begin
            cnt_d   = '0;
            state_d = S_RUN;
`ifdef IPF_SEQ_STRIDE2_EN
            ph_d    = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end
      S_RUN: begin
        i_in_ready = 1'b1;
        if (i_in_valid) begin
          ctrl_d    = C_START;
          i_valid_d = 1'b1;
          i_data_d  = i_in_data;
          wgroup_d  = grp_beat;
`ifdef IPF_SEQ_STRIDE2_EN
          ph_d      = ~ph_q;
`endif
          if (cnt_q == sbeats - 11'd1) begin
            cnt_d = '0;
            if (round_q == rlast) begin
              drn_d   = '0;
              state_d = S_DRAIN;
            end else begin
              round_d = round_q + 2'd1;
              state_d = S_PRE;
            end
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end
      S_DRAIN: begin
        drn_d = drn_q + 4'd1;
        if (drn_q == DRN_LAST) state_d = S_END;
      end
      S_END: begin
        ctrl_d = C_END;
        if (finish) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      round_q   <= '0;
      drn_q     <= '0;
      tiles_q   <= '0;
      group_q   <= '0;
      wsize_q   <= '0;
      stride_q  <= 1'b0;
      pad_q     <= '0;
      ctrl_q    <= C_HOLD;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      i_valid_q <= 1'b0;
      i_data_q  <= '0;
      wgroup_q  <= '0;
      wround_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IPF_SEQ_STRIDE2_EN
      ph_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      round_q   <= round_d;
      drn_q     <= drn_d;
      tiles_q   <= tiles_d;
      group_q   <= group_d;
      wsize_q   <= wsize_d;
      stride_q  <= stride_d;
      pad_q     <= pad_d;
      ctrl_q    <= ctrl_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      i_valid_q <= i_valid_d;
      i_data_q  <= i_data_d;
      wgroup_q  <= wgroup_d;
      wround_q  <= wround_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef IPF_SEQ_STRIDE2_EN
      ph_q      <= ph_d;
`endif
    end
  end

  assign ctrl      = ctrl_q;
  assign w_valid   = w_valid_q;
  assign w_data    = w_data_q;
  assign i_valid   = i_valid_q;
  assign i_data    = i_data_q;
  assign Wsize     = wsize_q;
  assign stride    = stride_q;
  assign RLPadding = pad_q;
  assign wgroup    = wgroup_q;
  assign wround    = wround_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_ipf_seq.sv
// tb_ipf_seq: randomized bench for ipf_seq against a queue-based layer model.
// The model expands each accepted layer into its list of expected IPF beats.
module tb_ipf_seq;
  localparam int DW = 64;
  localparam int DC = 10;
`ifdef IPF_SEQ_STRIDE2_EN
  localparam bit STRIDE2 = 1'b1;
`else
  localparam bit STRIDE2 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid, cfg_ready, cfg_stride;
  logic [1:0] cfg_wsize, cfg_pad;
  logic [7:0] cfg_tiles;
  logic [3:0] cfg_group;
  logic w_in_valid, w_in_ready, i_in_valid, i_in_ready;
  logic [DW-1:0] w_in_data, i_in_data, w_data, i_data;
  logic [1:0] ctrl, Wsize, RLPadding;
  logic w_valid, i_valid, stride, finish, done, err;
  logic [3:0] wgroup;
  logic [2:0] wround;

  always #5 clk = ~clk;

  ipf_seq #(.DATA_W(DW), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_wsize(cfg_wsize), .cfg_stride(cfg_stride),
    .cfg_tiles(cfg_tiles), .cfg_group(cfg_group), .cfg_pad(cfg_pad),
    .w_in_valid(w_in_valid), .w_in_ready(w_in_ready), .w_in_data(w_in_data),
    .i_in_valid(i_in_valid), .i_in_ready(i_in_ready), .i_in_data(i_in_data),
    .ctrl(ctrl), .w_valid(w_valid), .w_data(w_data),
    .i_valid(i_valid), .i_data(i_data),
    .Wsize(Wsize), .stride(stride), .RLPadding(RLPadding),
    .wgroup(wgroup), .wround(wround),
    .finish(finish), .done(done), .err(err)
  );

  // kind: 0 weight beat, 1 input beat, 2 drain cycle, 3 end/wait-finish
  typedef struct {
    int         kind;
    logic [1:0] ctrl;
    logic [3:0] wg;
    logic [2:0] wr;
  } item_t;

  item_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  logic [1:0] e_ctrl, e_wsize, e_pad;
  logic e_wv, e_iv, e_done, e_err, e_stride;
  logic [DW-1:0] e_wd, e_id;
  logic [3:0] e_wg;
  logic [2:0] e_wr;

  function automatic void build(input logic [1:0] ws, input logic st,
                                input logic [7:0] tl, input logic [3:0] gp);
    int w, p, r, s;
    bit s2;
    s2 = st && STRIDE2;
    w = (ws == 2'd0) ? 18 : 25;
    p = 2 + 2 * int'(ws);
    r = (ws == 2'd0) ? 1 : (ws == 2'd1) ? 2 : (s2 ? 2 : 4);
    s = (8 - p) + 8 * int'(tl);
    for (int i = 0; i < w; i++) q.push_back(item_t'{0, 2'd2, 4'd0, 3'd0});
    for (int rr = 0; rr < r; rr++) begin
      for (int i = 0; i < p; i++) q.push_back(item_t'{1, 2'd2, 4'd0, 3'(rr)});
      for (int i = 0; i < s; i++)
        q.push_back(item_t'{1, 2'd1, s2 ? 4'(i % 2) : gp, 3'(rr)});
    end
    for (int i = 0; i < DC; i++) q.push_back(item_t'{2, 2'd2, 4'd0, 3'd0});
    q.push_back(item_t'{3, 2'd0, 4'd0, 3'd0});
  endfunction

  always @(posedge clk) begin
    e_ctrl <= 2'd2;
    e_wv   <= 1'b0;
    e_iv   <= 1'b0;
    e_done <= 1'b0;
    e_err  <= 1'b0;
    if (rst) begin
      q.delete();
      e_wsize  <= 2'd0;
      e_stride <= 1'b0;
      e_pad    <= 2'd0;
      armed    <= 1'b1;
    end else if (q.size() == 0) begin
      if (cfg_valid) begin
        if (cfg_wsize == 2'd3) begin
          e_err <= 1'b1;
        end else begin
          build(cfg_wsize, cfg_stride, cfg_tiles, cfg_group);
          e_wsize  <= cfg_wsize;
          e_stride <= cfg_stride & STRIDE2;
          e_pad    <= cfg_pad;
        end
      end
    end else if (q[0].kind == 0) begin
      if (w_in_valid) begin
        e_wv <= 1'b1;
        e_wd <= w_in_data;
        e_wr <= 3'd0;
        void'(q.pop_front());
      end
    end else if (q[0].kind == 1) begin
      if (i_in_valid) begin
        e_iv   <= 1'b1;
        e_id   <= i_in_data;
        e_ctrl <= q[0].ctrl;
        e_wg   <= q[0].wg;
        e_wr   <= q[0].wr;
        void'(q.pop_front());
      end
    end else if (q[0].kind == 2) begin
      void'(q.pop_front());
    end else begin
      e_ctrl <= 2'd0;
      if (finish) begin
        e_done <= 1'b1;
        void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (armed) begin
      chk("ctrl", {62'd0, ctrl}, {62'd0, e_ctrl});
      chk("w_valid", {63'd0, w_valid}, {63'd0, e_wv});
      chk("i_valid", {63'd0, i_valid}, {63'd0, e_iv});
      chk("done", {63'd0, done}, {63'd0, e_done});
      chk("err", {63'd0, err}, {63'd0, e_err});
      chk("cfg_ready", {63'd0, cfg_ready}, {63'd0, q.size() == 0});
      chk("w_in_ready", {63'd0, w_in_ready}, {63'd0, q.size() != 0 && q[0].kind == 0});
      chk("i_in_ready", {63'd0, i_in_ready}, {63'd0, q.size() != 0 && q[0].kind == 1});
      chk("Wsize", {62'd0, Wsize}, {62'd0, e_wsize});
      chk("stride", {63'd0, stride}, {63'd0, e_stride});
      chk("RLPadding", {62'd0, RLPadding}, {62'd0, e_pad});
      if (e_wv) begin
        chk("w_data", w_data, e_wd);
        chk("wround_w", {61'd0, wround}, {61'd0, e_wr});
      end
      if (e_iv) begin
        chk("i_data", i_data, e_id);
        chk("wround_i", {61'd0, wround}, {61'd0, e_wr});
      end
      if (e_iv && e_ctrl == 2'd1) chk("wgroup", {60'd0, wgroup}, {60'd0, e_wg});
    end
  endtask

  int n_w, n_hv, n_st, n_dr, lat, end_cyc, l0;

  task automatic run_layer(input logic [1:0] ws, input logic st, input logic [7:0] tl,
                           input logic [3:0] gp, input logic [1:0] pd,
                           input int pw, input int pi, input int bub,
                           input bit fin_now, input bit rst_drain);
    int k, dcnt;
    bit seen_st, seen_end, stop;
    n_w = 0; n_hv = 0; n_st = 0; n_dr = 0; lat = -1; end_cyc = -1;
    seen_st = 0; seen_end = 0; stop = 0; dcnt = 0;
    cfg_valid = 1'b1; cfg_wsize = ws; cfg_stride = st;
    cfg_tiles = tl; cfg_group = gp; cfg_pad = pd;
    tick();
    cfg_valid = 1'b0;
    k = 0;
    while (q.size() != 0 && k < 20000 && !stop) begin
      w_in_valid = ($urandom_range(0, 99) < pw);
      w_in_data  = {$urandom, $urandom};
      i_in_valid = ($urandom_range(0, 99) < pi) && !(k >= bub && k < bub + 3);
      i_in_data  = {$urandom, $urandom};
      finish     = fin_now ? (ctrl == 2'd0) : ($urandom_range(0, 3) == 0);
      if (rst_drain && q[0].kind == 2) begin
        dcnt++;
        if (dcnt == 4) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          chk("rst_drain_ctrl", {62'd0, ctrl}, 64'd2);
          chk("rst_drain_ival", {63'd0, i_valid}, 64'd0);
          chk("rst_drain_wround", {61'd0, wround}, 64'd0);
          chk("rst_drain_cfg_ready", {63'd0, cfg_ready}, 64'd1);
          stop = 1;
        end
      end
      if (!stop) begin
        tick();
        k++;
        if (w_valid) n_w++;
        if (ctrl == 2'd2 && i_valid) n_hv++;
        if (ctrl == 2'd1) begin n_st++; seen_st = 1; end
        if (seen_st && !seen_end && ctrl == 2'd2 && !i_valid) n_dr++;
        if (ctrl == 2'd0 && !seen_end) begin end_cyc = k; seen_end = 1; end
        if (done) lat = k;
      end
    end
    chk("layer_timeout", 64'(q.size()), 64'd0);
    if (q.size() != 0) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_wsize = 2'd0; cfg_stride = 1'b0;
    cfg_tiles = 8'd0; cfg_group = 4'd0; cfg_pad = 2'd0;
    w_in_valid = 1'b0; w_in_data = '0; i_in_valid = 1'b0; i_in_data = '0;
    finish = 1'b0;
    repeat (3) tick();
    chk("reset_ctrl", {62'd0, ctrl}, 64'd2);
    chk("reset_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    rst = 1'b0;
    tick();

    run_layer(2'd0, 1'b0, 8'd1, 4'd1, 2'd2, 100, 100, -10, 1'b1, 1'b0);
    chk("t1_wbeats", 64'(n_w), 64'd18);
    chk("t1_preload", 64'(n_hv), 64'd2);
    chk("t1_starts", 64'(n_st), 64'd14);
    chk("t1_drain", 64'(n_dr), 64'd10);
    chk("t1_done_after_end", 64'(lat - end_cyc), 64'd1);
    chk("t1_latency", 64'(lat), 64'd46);
    l0 = lat;

    run_layer(2'd0, 1'b0, 8'd1, 4'd1, 2'd0, 100, 100, 24, 1'b1, 1'b0);
    chk("bub_starts", 64'(n_st), 64'd14);
    chk("bub_holds", 64'(n_dr), 64'd13);
    chk("bub_shift", 64'(lat - l0), 64'd3);

    run_layer(2'd1, 1'b0, 8'd1, 4'd5, 2'd1, 100, 100, -10, 1'b1, 1'b0);
    chk("t5_wbeats", 64'(n_w), 64'd25);
    chk("t5_preload", 64'(n_hv), 64'd8);
    chk("t5_starts", 64'(n_st), 64'd24);
    chk("t5_latency", 64'(lat), 64'd69);

    cfg_valid = 1'b1; cfg_wsize = 2'd3;
    tick();
    cfg_valid = 1'b0;
    chk("ill_err", {63'd0, err}, 64'd1);
    chk("ill_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("ill_wsize_hold", {62'd0, Wsize}, 64'd1);
    tick();
    chk("ill_err_pulse", {63'd0, err}, 64'd0);

    run_layer(2'd2, 1'b1, 8'd1, 4'd9, 2'd3, 100, 100, -10, 1'b1, 1'b0);
    chk("t7_starts", 64'(n_st), STRIDE2 ? 64'd20 : 64'd40);
    chk("t7_latency", 64'(lat), STRIDE2 ? 64'd69 : 64'd101);
    chk("t7_stride", {63'd0, stride}, {63'd0, STRIDE2});

    run_layer(2'd0, 1'b0, 8'd0, 4'd3, 2'd1, 100, 100, -10, 1'b1, 1'b1);
    chk("rst_wsize", {62'd0, Wsize}, 64'd0);

    for (int n = 0; n < 30; n++) begin
      run_layer(2'($urandom_range(0, 2)), 1'($urandom), 8'($urandom_range(0, 3)),
                4'($urandom), 2'($urandom),
                $urandom_range(50, 100), $urandom_range(50, 100), -10, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1; cfg_wsize = 2'd3;
        tick();
        cfg_valid = 1'b0;
      end
    end
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
